// File: rtl/square_selector.sv
// -----------------------------------------------------------------------------
// square_selector
//
// Purpose:
//   Cursor and move controller for a 3x3 tic-tac-toe board shown on a
//   640x480 screen. Button presses move a cursor over the board and place the
//   current player's mark. The block also reports the pixel bounds of the cell
//   under the cursor so a video stage can highlight it.
//
// Ports:
//   clk                       rising-edge clock for all state
//   rst                       synchronous, active-high reset
//   btn_up/down/left/right    debounced cursor-move button levels
//   btn_select                debounced "place mark" button level
//   sel_row, sel_col          cursor position, each 0..2
//   selected_square_startX/endX   horizontal pixel bounds of the cursor cell
//   selected_square_startY/endY   vertical pixel bounds of the cursor cell
//   board_p1, board_p2        occupancy per player, bit index = row*3+col
//   turn                      player to move (0 = P1, 1 = P2)
//   place_ok, place_err       one-cycle result pulses of a placement attempt
//   board_full                every cell is occupied
// -----------------------------------------------------------------------------
module square_selector #(
  parameter int unsigned H_DIV1 = 213,
  parameter int unsigned H_DIV2 = 426,
  parameter int unsigned H_END  = 640,
  parameter int unsigned V_DIV1 = 160,
  parameter int unsigned V_DIV2 = 320,
  parameter int unsigned V_END  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  output logic [1:0]  sel_row,
  output logic [1:0]  sel_col,
  output logic [15:0] selected_square_startX,
  output logic [15:0] selected_square_endX,
  output logic [9:0]  selected_square_startY,
  output logic [9:0]  selected_square_endY,
  output logic [8:0]  board_p1,
  output logic [8:0]  board_p2,
  output logic        turn,
  output logic        place_ok,
  output logic        place_err,
  output logic        board_full
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Grid line positions, zero-extended/truncated to the output port widths
  localparam logic [15:0] X_ZERO = 16'd0;
  localparam logic [15:0] X_DIV1 = 16'(H_DIV1);
  localparam logic [15:0] X_DIV2 = 16'(H_DIV2);
  localparam logic [15:0] X_END  = 16'(H_END);
  localparam logic [9:0]  Y_ZERO = 10'd0;
  localparam logic [9:0]  Y_DIV1 = 10'(V_DIV1);
  localparam logic [9:0]  Y_DIV2 = 10'(V_DIV2);
  localparam logic [9:0]  Y_END  = 10'(V_END);

  logic [1:0] r_state;
  logic [1:0] r_row;
  logic [1:0] r_col;
  logic [8:0] r_boardP1;
  logic [8:0] r_boardP2;
  logic       r_turn;
  logic       r_placeOk;
  logic       r_placeErr;

  logic       w_anyBtn;
  logic [3:0] w_cellIdx;
  logic [8:0] w_cellMask;
  logic       w_cellTaken;
  logic [8:0] w_occupied;

  // Modulo-3 cursor steps. Out-of-range inputs cannot occur, but both
  // functions still map them back into 0..2.
  function automatic logic [1:0] wrapInc(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] wrapDec(input logic [1:0] v);
    return (v == 2'd0 || v == 2'd3) ? 2'd2 : v - 2'd1;
  endfunction

  assign w_anyBtn   = btn_up | btn_down | btn_left | btn_right | btn_select;
  assign w_occupied = r_boardP1 | r_boardP2;

  // Linear cell index of the cursor; the one-hot mask picks its board bit.
  assign w_cellIdx   = ({2'b00, r_row} * 4'd3) + {2'b00, r_col};
  assign w_cellMask  = 9'd1 << w_cellIdx;
  assign w_cellTaken = |(w_occupied & w_cellMask);

  // Control FSM plus all registered state. IDLE acts on at most one button
  // (select has top priority, then up, down, left, right). CHECK performs the
  // placement decision and ignores buttons. HOLD swallows held or chorded
  // buttons until everything is released so each press does one thing.
  // A full board needs no special case: every cell is taken, so select
  // naturally reports place_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_row      <= 2'd1;
      r_col      <= 2'd1;
      r_boardP1  <= 9'd0;
      r_boardP2  <= 9'd0;
      r_turn     <= 1'b0;
      r_placeOk  <= 1'b0;
      r_placeErr <= 1'b0;
    end else begin
      r_placeOk  <= 1'b0;
      r_placeErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (btn_select) begin
            r_state <= ST_CHECK;
          end else if (btn_up) begin
            r_row   <= wrapDec(r_row);
            r_state <= ST_HOLD;
          end else if (btn_down) begin
            r_row   <= wrapInc(r_row);
            r_state <= ST_HOLD;
          end else if (btn_left) begin
            r_col   <= wrapDec(r_col);
            r_state <= ST_HOLD;
          end else if (btn_right) begin
            r_col   <= wrapInc(r_col);
            r_state <= ST_HOLD;
          end
        end

        ST_CHECK: begin
          if (!w_cellTaken) begin
            if (r_turn) begin
              r_boardP2 <= r_boardP2 | w_cellMask;
            end else begin
              r_boardP1 <= r_boardP1 | w_cellMask;
            end
            r_turn    <= ~r_turn;
            r_placeOk <= 1'b1;
          end else begin
            r_placeErr <= 1'b1;
          end
          r_state <= ST_HOLD;
        end

        ST_HOLD: begin
          if (!w_anyBtn) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Column to horizontal bounds of the highlighted cell
  always_comb begin
    selected_square_startX = X_ZERO;
    selected_square_endX   = X_DIV1;
    case (r_col)
      2'd1: begin
        selected_square_startX = X_DIV1;
        selected_square_endX   = X_DIV2;
      end
      2'd2: begin
        selected_square_startX = X_DIV2;
        selected_square_endX   = X_END;
      end
      default: begin
        selected_square_startX = X_ZERO;
        selected_square_endX   = X_DIV1;
      end
    endcase
  end

  // Row to vertical bounds of the highlighted cell
  always_comb begin
    selected_square_startY = Y_ZERO;
    selected_square_endY   = Y_DIV1;
    case (r_row)
      2'd1: begin
        selected_square_startY = Y_DIV1;
        selected_square_endY   = Y_DIV2;
      end
      2'd2: begin
        selected_square_startY = Y_DIV2;
        selected_square_endY   = Y_END;
      end
      default: begin
        selected_square_startY = Y_ZERO;
        selected_square_endY   = Y_DIV1;
      end
    endcase
  end

  assign sel_row    = r_row;
  assign sel_col    = r_col;
  assign board_p1   = r_boardP1;
  assign board_p2   = r_boardP2;
  assign turn       = r_turn;
  assign place_ok   = r_placeOk;
  assign place_err  = r_placeErr;
  assign board_full = (w_occupied == 9'h1FF);

endmodule

// File: tb/tb_square_selector.sv
// -----------------------------------------------------------------------------
// tb_square_selector
//
// Self-checking bench for square_selector: a directed vector table, a few
// hand-written multi-cycle sequences and a long randomized run, all compared
// every cycle against a game-level reference model.
// -----------------------------------------------------------------------------
module tb_square_selector;

  // Button encoding used throughout: {select, up, down, left, right}
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_SEL   = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  logic        clk;
  logic        rst;
  logic        btnUp, btnDown, btnLeft, btnRight, btnSelect;
  logic [1:0]  selRow, selCol;
  logic [15:0] startX, endX;
  logic [9:0]  startY, endY;
  logic [8:0]  boardP1, boardP2;
  logic        turn, placeOk, placeErr, boardFull;

  square_selector dut (
    .clk                    (clk),
    .rst                    (rst),
    .btn_up                 (btnUp),
    .btn_down               (btnDown),
    .btn_left               (btnLeft),
    .btn_right              (btnRight),
    .btn_select             (btnSelect),
    .sel_row                (selRow),
    .sel_col                (selCol),
    .selected_square_startX (startX),
    .selected_square_endX   (endX),
    .selected_square_startY (startY),
    .selected_square_endY   (endY),
    .board_p1               (boardP1),
    .board_p2               (boardP2),
    .turn                   (turn),
    .place_ok               (placeOk),
    .place_err              (placeErr),
    .board_full             (boardFull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: the game as a list of cells (0 empty, 1 P1, 2 P2), a
  // cursor, whose turn it is, and whether the controller is ready for a new
  // press (0), about to judge a placement (1) or waiting for release (2).
  int mCells[9];
  int mRow, mCol, mTurn, mOk, mErr, mPhase;
  int xGrid[4] = '{0, 213, 426, 640};
  int yGrid[4] = '{0, 160, 320, 480};

  typedef struct {
    logic       rst;
    logic [4:0] btn;
    int row, col, sx, ex, sy, ey, p1, p2, trn, ok, err;
  } vec_t;

  vec_t vectors[21];

  function automatic vec_t mkVec(logic r, logic [4:0] b, int row, int col,
                                 int sx, int ex, int sy, int ey, int p1,
                                 int p2, int trn, int ok, int err);
    vec_t v;
    v.rst = r; v.btn = b; v.row = row; v.col = col; v.sx = sx; v.ex = ex;
    v.sy = sy; v.ey = ey; v.p1 = p1; v.p2 = p2; v.trn = trn; v.ok = ok;
    v.err = err;
    return v;
  endfunction

  function automatic void check(string name, int act, int exp);
    checkCount++;
    if (act == exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endfunction

  // One clock of game rules, evaluated on the inputs present at the edge
  function automatic void modelClock(logic r, logic [4:0] b);
    mOk  = 0;
    mErr = 0;
    if (r) begin
      foreach (mCells[i]) mCells[i] = 0;
      mRow = 1; mCol = 1; mTurn = 0; mPhase = 0;
      return;
    end
    case (mPhase)
      0: begin
        if (b[4])      mPhase = 1;
        else if (b[3]) begin mRow = (mRow + 2) % 3; mPhase = 2; end
        else if (b[2]) begin mRow = (mRow + 1) % 3; mPhase = 2; end
        else if (b[1]) begin mCol = (mCol + 2) % 3; mPhase = 2; end
        else if (b[0]) begin mCol = (mCol + 1) % 3; mPhase = 2; end
      end
      1: begin
        if (mCells[mRow * 3 + mCol] == 0) begin
          mCells[mRow * 3 + mCol] = mTurn + 1;
          mTurn = 1 - mTurn;
          mOk = 1;
        end else begin
          mErr = 1;
        end
        mPhase = 2;
      end
      default: if (b == 5'b0) mPhase = 0;
    endcase
  endfunction

  task automatic checkOutput();
    int expP1, expP2, full;
    expP1 = 0; expP2 = 0; full = 1;
    for (int i = 0; i < 9; i++) begin
      if (mCells[i] == 1) expP1 |= (1 << i);
      if (mCells[i] == 2) expP2 |= (1 << i);
      if (mCells[i] == 0) full = 0;
    end
    check("sel_row",    int'(selRow),    mRow);
    check("sel_col",    int'(selCol),    mCol);
    check("startX",     int'(startX),    xGrid[mCol]);
    check("endX",       int'(endX),      xGrid[mCol + 1]);
    check("startY",     int'(startY),    yGrid[mRow]);
    check("endY",       int'(endY),      yGrid[mRow + 1]);
    check("board_p1",   int'(boardP1),   expP1);
    check("board_p2",   int'(boardP2),   expP2);
    check("turn",       int'(turn),      mTurn);
    check("place_ok",   int'(placeOk),   mOk);
    check("place_err",  int'(placeErr),  mErr);
    check("board_full", int'(boardFull), full);
    check("no_overlap", int'(boardP1 & boardP2), 0);
  endtask

  // Drive inputs for one cycle, advance the model, then compare #1 after
  // the edge.
  task automatic applyStimulus(logic r, logic [4:0] b);
    rst       = r;
    btnSelect = b[4];
    btnUp     = b[3];
    btnDown   = b[2];
    btnLeft   = b[1];
    btnRight  = b[0];
    @(posedge clk);
    modelClock(r, b);
    #1;
    checkOutput();
  endtask

  task automatic pressRelease(logic [4:0] b);
    applyStimulus(1'b0, b);
    applyStimulus(1'b0, B_NONE);
    applyStimulus(1'b0, B_NONE);
  endtask

  initial begin
    int okPulses, errPulses;
    rst = 1'b1;
    btnUp = 1'b0; btnDown = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
    btnSelect = 1'b0;
    mRow = 1; mCol = 1; mTurn = 0; mPhase = 0; mOk = 0; mErr = 0;
    foreach (mCells[i]) mCells[i] = 0;

    // Directed vectors: rst, btn, row, col, sx, ex, sy, ey, p1, p2, turn, ok, err
    vectors[0]  = mkVec(1, B_NONE,  1, 1, 213, 426, 160, 320, 0, 0, 0, 0, 0);
    vectors[1]  = mkVec(0, B_RIGHT, 1, 2, 426, 640, 160, 320, 0, 0, 0, 0, 0);
    vectors[2]  = mkVec(0, B_NONE,  1, 2, 426, 640, 160, 320, 0, 0, 0, 0, 0);
    vectors[3]  = mkVec(0, B_RIGHT, 1, 0,   0, 213, 160, 320, 0, 0, 0, 0, 0);
    vectors[4]  = mkVec(0, B_NONE,  1, 0,   0, 213, 160, 320, 0, 0, 0, 0, 0);
    vectors[5]  = mkVec(0, B_SEL,   1, 0,   0, 213, 160, 320, 0, 0, 0, 0, 0);
    vectors[6]  = mkVec(0, B_NONE,  1, 0,   0, 213, 160, 320, 8, 0, 1, 1, 0);
    vectors[7]  = mkVec(0, B_NONE,  1, 0,   0, 213, 160, 320, 8, 0, 1, 0, 0);
    vectors[8]  = mkVec(0, B_SEL,   1, 0,   0, 213, 160, 320, 8, 0, 1, 0, 0);
    vectors[9]  = mkVec(0, B_NONE,  1, 0,   0, 213, 160, 320, 8, 0, 1, 0, 1);
    vectors[10] = mkVec(0, B_NONE,  1, 0,   0, 213, 160, 320, 8, 0, 1, 0, 0);
    vectors[11] = mkVec(0, B_UP,    0, 0,   0, 213,   0, 160, 8, 0, 1, 0, 0);
    vectors[12] = mkVec(0, B_NONE,  0, 0,   0, 213,   0, 160, 8, 0, 1, 0, 0);
    vectors[13] = mkVec(0, B_LEFT,  0, 2, 426, 640,   0, 160, 8, 0, 1, 0, 0);
    vectors[14] = mkVec(0, B_NONE,  0, 2, 426, 640,   0, 160, 8, 0, 1, 0, 0);
    vectors[15] = mkVec(0, B_DOWN,  1, 2, 426, 640, 160, 320, 8, 0, 1, 0, 0);
    vectors[16] = mkVec(0, B_NONE,  1, 2, 426, 640, 160, 320, 8, 0, 1, 0, 0);
    vectors[17] = mkVec(0, B_DOWN | B_LEFT,
                                    2, 2, 426, 640, 320, 480, 8, 0, 1, 0, 0);
    vectors[18] = mkVec(0, B_NONE,  2, 2, 426, 640, 320, 480, 8, 0, 1, 0, 0);
    vectors[19] = mkVec(0, B_UP | B_DOWN,
                                    1, 2, 426, 640, 160, 320, 8, 0, 1, 0, 0);
    vectors[20] = mkVec(0, B_NONE,  1, 2, 426, 640, 160, 320, 8, 0, 1, 0, 0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vectors[i].rst, vectors[i].btn);
      check("vec_row",  int'(selRow),   vectors[i].row);
      check("vec_col",  int'(selCol),   vectors[i].col);
      check("vec_sx",   int'(startX),   vectors[i].sx);
      check("vec_ex",   int'(endX),     vectors[i].ex);
      check("vec_sy",   int'(startY),   vectors[i].sy);
      check("vec_ey",   int'(endY),     vectors[i].ey);
      check("vec_p1",   int'(boardP1),  vectors[i].p1);
      check("vec_p2",   int'(boardP2),  vectors[i].p2);
      check("vec_turn", int'(turn),     vectors[i].trn);
      check("vec_ok",   int'(placeOk),  vectors[i].ok);
      check("vec_err",  int'(placeErr), vectors[i].err);
    end

    // Select latency from reset: pulse two cycles after the press
    applyStimulus(1'b1, B_NONE);
    check("rst_full", int'(boardFull), 0);
    applyStimulus(1'b0, B_SEL);
    check("lat_ok_n1", int'(placeOk), 0);
    applyStimulus(1'b0, B_NONE);
    check("lat_ok_n2", int'(placeOk), 1);
    check("lat_p1",    int'(boardP1), 9'h010);
    check("lat_turn",  int'(turn),    1);
    applyStimulus(1'b0, B_NONE);
    check("lat_ok_n3", int'(placeOk), 0);
    applyStimulus(1'b0, B_SEL);
    applyStimulus(1'b0, B_NONE);
    check("dup_err",  int'(placeErr), 1);
    check("dup_p1",   int'(boardP1),  9'h010);
    check("dup_turn", int'(turn),     1);
    applyStimulus(1'b0, B_NONE);

    // Chorded up+select held for 20 cycles: one placement, no move
    applyStimulus(1'b1, B_NONE);
    okPulses = 0; errPulses = 0;
    repeat (20) begin
      applyStimulus(1'b0, B_UP | B_SEL);
      okPulses  += int'(placeOk);
      errPulses += int'(placeErr);
      check("hold_row", int'(selRow), 1);
    end
    check("hold_ok_pulses",  okPulses,  1);
    check("hold_err_pulses", errPulses, 0);
    applyStimulus(1'b0, B_NONE);
    applyStimulus(1'b0, B_UP);
    check("after_up_row", int'(selRow), 0);
    check("after_up_sy",  int'(startY), 0);
    check("after_up_ey",  int'(endY),   160);

    // Reset while judging a placement wipes everything, no pulse escapes
    applyStimulus(1'b1, B_NONE);
    applyStimulus(1'b0, B_SEL);
    applyStimulus(1'b1, B_SEL);
    check("rstchk_ok",   int'(placeOk),  0);
    check("rstchk_err",  int'(placeErr), 0);
    check("rstchk_p1",   int'(boardP1),  0);
    check("rstchk_row",  int'(selRow),   1);
    check("rstchk_col",  int'(selCol),   1);
    check("rstchk_turn", int'(turn),     0);
    applyStimulus(1'b0, B_NONE);
    check("rstchk_ok2",  int'(placeOk),  0);

    // Fill every cell by alternating players, then try once more
    applyStimulus(1'b1, B_NONE);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pressRelease(B_SEL);
        pressRelease(B_RIGHT);
      end
      pressRelease(B_DOWN);
    end
    check("fill_full",    int'(boardFull),           1);
    check("fill_union",   int'(boardP1 | boardP2),   9'h1FF);
    check("fill_overlap", int'(boardP1 & boardP2),   0);
    check("fill_p1_cnt",  $countones(boardP1),       5);
    applyStimulus(1'b0, B_SEL);
    applyStimulus(1'b0, B_NONE);
    check("full_err", int'(placeErr), 1);
    check("full_ok",  int'(placeOk),  0);
    applyStimulus(1'b0, B_NONE);

    // Randomized play against the model
    applyStimulus(1'b1, B_NONE);
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [4:0] b;
      r = ($urandom_range(0, 199) == 0);
      b = ($urandom_range(0, 2) == 0) ? (5'($urandom) & 5'($urandom)) : B_NONE;
      applyStimulus(r, b);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
